// File: rtl/fdiv_round.sv
// fdiv_round: normalise, round-to-nearest-even and pack a divider's
// quotient/remainder into an IEEE-754 single-precision result.
module fdiv_round #(
    parameter int K = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         sign_in,
    input  logic [9:0]   exp_in,
    input  logic         zero_in,
    input  logic [31:0]  q,
    input  logic [K-1:0] r,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [31:0]  result,
    output logic         overflow,
    output logic         underflow,
    output logic         inexact
);

    logic en1, en2;

    logic               v1_q, v2_q;
    logic               sign1_q, zero1_q;
    logic [23:0]        mant1_q;
    logic               g1_q, st1_q;
    logic signed [10:0] e1_q;

    logic [23:0]        mant_d;
    logic               g_d, st_d;
    logic signed [10:0] e_d, exp_ext;

    logic [31:0]        result_q, result_d;
    logic               ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

    logic               inc;
    logic [24:0]        sum;
    logic [22:0]        frac;
    logic signed [10:0] e_r;
    logic               unused_msb;

    assign en2     = !v2_q || m_ready;
    assign en1     = !v1_q || en2;
    assign s_ready = en1;

    assign m_valid   = v2_q;
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign inexact   = inx_q;

    assign exp_ext = signed'({exp_in[9], exp_in});

    // S1 normalise: pick mantissa window by the quotient's leading bit
    always_comb begin
        mant_d = q[31:8];
        g_d    = q[7];
        st_d   = (|q[6:0]) || (|r);
        e_d    = exp_ext;
        if (!q[31]) begin
            mant_d = q[30:7];
            g_d    = q[6];
            st_d   = (|q[5:0]) || (|r);
            e_d    = exp_ext - 11'sd1;
        end
    end

    // S1 valid bit
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
        end else if (en1) begin
            v1_q <= s_valid;
        end
    end

    // S1 payload, loaded only on an input transfer
    always_ff @(posedge clk) begin
        if (en1 && s_valid) begin
            sign1_q <= sign_in;
            zero1_q <= zero_in;
            mant1_q <= mant_d;
            g1_q    <= g_d;
            st1_q   <= st_d;
            e1_q    <= e_d;
        end
    end

    // S2 round-to-nearest-even, carry renormalise, range check, pack
    always_comb begin
        inc        = g1_q && (st1_q || mant1_q[0]);
        sum        = {1'b0, mant1_q} + {24'd0, inc};
        unused_msb = sum[23];
        frac       = sum[22:0];
        e_r        = e1_q;
        if (sum[24]) begin
            frac = 23'd0;
            e_r  = e1_q + 11'sd1;
        end
        result_d = {sign1_q, e_r[7:0], frac};
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        inx_d    = g1_q || st1_q;
        if (zero1_q) begin
            result_d = {sign1_q, 31'd0};
            inx_d    = 1'b0;
        end else if (e1_q <= 11'sd0) begin
            result_d = {sign1_q, 31'd0};
            unf_d    = 1'b1;
            inx_d    = 1'b1;
        end else if (e_r >= 11'sd255) begin
            result_d = {sign1_q, 8'hFF, 23'd0};
            ovf_d    = 1'b1;
            inx_d    = 1'b1;
        end
    end

    // S2 registers; output held while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q     <= 1'b0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else if (en2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                result_q <= result_d;
                ovf_q    <= ovf_d;
                unf_q    <= unf_d;
                inx_q    <= inx_d;
            end
        end
    end

endmodule
